// File: rtl/shift_sequencer_pkg.sv
// Shared opcodes, state encoding and helpers for the multi-cycle shift sequencer.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Distance to shift this cycle: whatever is left, capped at the step size.
  function automatic logic [4:0] min_step(input logic [4:0] rem, input logic [4:0] step_max);
    return (rem < step_max) ? rem : step_max;
  endfunction

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between execute-stage control and the shift sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [4:0]       sh_amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             illegal;

  modport master (
    output start, op, a, sh_amt,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, op, a, sh_amt,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// Narrow one-cycle shifter: moves acc by at most STEP bits in the direction given by op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 3
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    case (op)
      OP_SLL:  acc_next = acc << s;
      OP_SRL:  acc_next = acc >> s;
      OP_SRA:  acc_next = $signed(acc) >>> s;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: iterates a STEP-bit shifter until the requested distance is consumed.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  localparam int         SW       = $clog2(STEP) + 1;
  localparam logic [4:0] STEP_MAX = 5'(STEP);

  state_t           state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [4:0]       rem_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] result_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             illegal_reg;

  logic [4:0]       s_full;
  logic [SW-1:0]    s_step;
  logic [WIDTH-1:0] acc_next;

  assign s_full = min_step(rem_reg, STEP_MAX);
  assign s_step = s_full[SW-1:0];

  shift_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .acc      (acc_reg),
    .op       (op_reg),
    .s        (s_step),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      rem_reg     <= '0;
      op_reg      <= '0;
      result_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (is_legal_op(bus.op)) begin
              op_reg   <= bus.op;
              acc_reg  <= bus.a;
              rem_reg  <= bus.sh_amt;
              busy_reg <= 1'b1;
              // A zero-distance shift skips RUN; the operand is already the answer.
              if (bus.sh_amt == 5'd0) begin
                state_reg  <= ST_DONE;
                done_reg   <= 1'b1;
                result_reg <= bus.a;
              end else begin
                state_reg <= ST_RUN;
              end
            end else begin
              illegal_reg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          rem_reg <= rem_reg - s_full;
          if (rem_reg == s_full) begin
            state_reg  <= ST_DONE;
            done_reg   <= 1'b1;
            result_reg <= acc_next;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.result  = result_reg;
  assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, result, busy window, illegal op, ignored starts, async reset.
module tb_shift_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  shift_sequencer_if #(.WIDTH(32)) sif ();

  shift_sequencer #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sif.busy); end
    total++; if (sif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", sif.done); end
    total++; if (sif.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", sif.illegal); end
    total++; if (sif.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", sif.result); end
    rst = 1'b0;
    $display("reset: busy=%b done=%b result=%h", sif.busy, sif.done, sif.result);
  endtask

  // Start one operation, then check done latency, result, and that busy spans exactly the operation.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [4:0] amt, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    sif.start = 1'b1; sif.op = op; sif.a = a; sif.sh_amt = amt;
    @(negedge clk);
    sif.start = 1'b0; sif.a = 32'h0; sif.sh_amt = 5'd0;
    lat = 0; busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (sif.busy === 1'b1) busy_cnt++;
      if (sif.done === 1'b1) begin lat = i; break; end
    end
    total++; if (lat != exp_lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    total++; if (sif.result !== exp_res) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, sif.result, exp_res); end
    total++; if (busy_cnt != exp_lat) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_cnt, exp_lat); end
    @(negedge clk);
    total++; if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      bad++; $display("FAIL %s_after got busy=%b done=%b exp busy=0 done=0", name, sif.busy, sif.done);
    end
    $display("%s: op=%b a=%h amt=%0d result=%h latency=%0d", name, op, a, amt, sif.result, lat);
  endtask

  task automatic test_shifts();
    run_op("sll_5",     3'b011, 32'h0000_0001,  5, 32'h0000_0020, 3);
    run_op("sra_31",    3'b101, 32'h8000_0000, 31, 32'hFFFF_FFFF, 9);
    run_op("srl_31",    3'b100, 32'h8000_0000, 31, 32'h0000_0001, 9);
    run_op("sra_pos_8", 3'b101, 32'h7000_0000,  8, 32'h0070_0000, 3);
    run_op("sll_12",    3'b011, 32'h1234_5678, 12, 32'h4567_8000, 4);
    run_op("sra_3",     3'b101, 32'hF000_000F,  3, 32'hFE00_0001, 2);
    run_op("srl_16",    3'b100, 32'h8000_0000, 16, 32'h0000_8000, 5);
  endtask

  task automatic test_zero_shift();
    run_op("srl_0", 3'b100, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1);
  endtask

  task automatic test_illegal();
    int done_cnt;
    @(negedge clk);
    sif.start = 1'b1; sif.op = 3'b110; sif.a = 32'h1111_1111; sif.sh_amt = 5'd4;
    @(negedge clk);
    sif.start = 1'b0;
    total++; if (sif.illegal !== 1'b1) begin bad++; $display("FAIL illegal_pulse got=%b exp=1", sif.illegal); end
    total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b exp=0", sif.busy); end
    total++; if (sif.result !== 32'hDEAD_BEEF) begin bad++; $display("FAIL illegal_result got=%h exp=deadbeef", sif.result); end
    @(negedge clk);
    total++; if (sif.illegal !== 1'b0) begin bad++; $display("FAIL illegal_width got=%b exp=0", sif.illegal); end
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (sif.done === 1'b1 || sif.busy === 1'b1) done_cnt++;
      @(negedge clk);
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL illegal_no_done got=%0d exp=0", done_cnt); end
    $display("illegal: op=110 result=%h", sif.result);
  endtask

  // Restart attempts mid-RUN and in the DONE cycle must both be dropped.
  task automatic test_back_to_back();
    int done_cnt;
    int done_at;
    logic busy_after;
    @(negedge clk);
    sif.start = 1'b1; sif.op = 3'b011; sif.a = 32'h0000_0001; sif.sh_amt = 5'd20;
    done_cnt = 0; done_at = 0; busy_after = 1'bx;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.done === 1'b1) begin done_cnt++; done_at = i; end
      if (i == 7) busy_after = sif.busy;
      if (i == 2 || i == 6) begin
        sif.start = 1'b1; sif.op = 3'b011; sif.a = 32'h0000_00FF; sif.sh_amt = 5'd1;
      end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt); end
    total++; if (done_at != 6) begin bad++; $display("FAIL b2b_done_cycle got=%0d exp=6", done_at); end
    total++; if (sif.result !== 32'h0010_0000) begin bad++; $display("FAIL b2b_result got=%h exp=00100000", sif.result); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL b2b_start_in_done got busy=%b exp=0", busy_after); end
    $display("back_to_back: dones=%0d at=%0d result=%h", done_cnt, done_at, sif.result);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    sif.start = 1'b1; sif.op = 3'b100; sif.a = 32'hFFFF_FFFF; sif.sh_amt = 5'd20;
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (sif.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", sif.busy); end
    total++; if (sif.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", sif.done); end
    total++; if (sif.result !== 32'h0) begin bad++; $display("FAIL midrst_result got=%h exp=0", sif.result); end
    $display("reset_mid_run: busy=%b result=%h", sif.busy, sif.result);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_sll_20", 3'b011, 32'h0000_0003, 20, 32'h0030_0000, 6);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    sif.start = 1'b0; sif.op = 3'b000; sif.a = 32'h0; sif.sh_amt = 5'd0;
    test_reset();
    test_shifts();
    test_zero_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that sequences a variable shift of one 32-bit operand in increments of at most STEP bits per cycle, so the processor does not need a full 32-bit barrel shifter in one cycle. It accepts a start pulse from the execute-stage control, iterates a narrow step shifter, and returns the result with a one-cycle done pulse. busy stalls the pipeline while the shift runs. It supports the ALU shift opcodes SLL (3'b011), SRL (3'b100) and SRA (3'b101).

Parameters:
WIDTH, 32, operand/result width in bits
STEP, 4, maximum shift distance per cycle; power of 2, 1..16

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  shift opcode: 011 SLL, 100 SRL, 101 SRA
a  input  WIDTH  signed operand, sampled with start
sh_amt  input  5  shift distance 0..31, sampled with start
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  shifted value; held until the next accepted start
illegal  output  1  one-cycle pulse; start sampled with an unsupported op

Behaviour:
- One clock (clk). rst is asynchronous and active-high. On rst: state=IDLE, busy=0, done=0, illegal=0, result=0, internal accumulator, remaining count and latched op all 0.
- States and transitions:
  - IDLE: wait for start.
  - RUN: perform one step per cycle.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- IDLE, start=1, op legal: latch op, load acc<=a, rem<=sh_amt.
  - sh_amt==0 -> next state DONE.
  - Otherwise -> next state RUN.
- IDLE, start=1, op illegal: illegal=1 next cycle for one cycle. State stays IDLE. result, busy and done are unchanged.
- RUN, each cycle:
  - s = min(rem, STEP).
  - acc <= step(acc, op, s); rem <= rem - s.
  - If rem - s == 0, next state is DONE and result <= final acc, registered on the same edge.
- Step rules:
  - SLL: zero-fill from LSB.
  - SRL: zero-fill from MSB.
  - SRA: replicate acc[WIDTH-1].
  - s==0 leaves acc unchanged.
  - Result equals the single-step full shift of a by sh_amt (a<<n, a>>n, a>>>n).
- Latency: start sampled at edge T gives done high in cycle T+1+ceil(sh_amt/STEP). For sh_amt=0 that is T+1. Worst case with defaults (31 bits, STEP=4) is T+9.
- busy: high from the cycle after the accepted start through the DONE cycle inclusive, low otherwise.
- start while busy is ignored (no queueing). start in the same cycle as done is also ignored, because state is DONE, not IDLE.
- op, a and sh_amt are don't-care outside the start-sampling cycle.
- Reset mid-RUN or mid-DONE aborts immediately with reset values. There is no done pulse for the aborted operation.
- rem is 5 bits and never underflows, because s <= rem.

Decomposition:
- Shared package (shift_pkg):
  - OP_SLL=3'b011, OP_SRL=3'b100, OP_SRA=3'b101.
  - State encoding ST_IDLE/ST_RUN/ST_DONE (2 bits).
  - Helper function min_step.
- One sub-module, shift_step: combinational. Inputs acc[WIDTH], op[3], s[$clog2(STEP)+1]; output next acc. Instantiated once; contains the signed arithmetic shift.

Test Plan:
- Reset, then start op=011, a=32'h0000_0001, sh_amt=5 -> busy for 3 cycles (RUN 4+1, then DONE); done in cycle T+3; result=32'h0000_0020.
- op=101, a=32'h8000_0000, sh_amt=31 -> done at T+9, result=32'hFFFF_FFFF; repeat with op=100 -> result=32'h0000_0001.
- sh_amt=0, op=100, a=32'hDEAD_BEEF -> done at T+1, result=32'hDEAD_BEEF, busy high exactly one cycle.
- op=3'b110 with start -> illegal pulses once, busy stays 0, result keeps its previous value, no done.
- start re-asserted with different a/sh_amt during RUN -> ignored; result matches the first request; done pulses once.
- rst asserted asynchronously mid-RUN (sh_amt=20) -> busy/done/result go 0 immediately; new start after release completes correctly.
